mc_control_unit: RTL and testbench

Multicycle control FSM that sequences the 32-bit multicycle datapath. It decodes the upper instruction field (CInstruction[31:20]) and evaluates the registered Z/N/V/C flags against the condition code. It drives every datapath select and write-enable, plus the memory read/write strobes with a ready handshake. It halts on an illegal instruction or a memory timeout.

---
 rtl/mc_ctrl_pkg.sv | 40 ++++
 rtl/mc_control_unit_if.sv | 10 +
 rtl/mc_cond_check.sv | 34 +++
 rtl/mc_control_unit.sv | 170 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// States, decode-field constants and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT, FETCH, DECODE, DP_EXEC, DP_WB, MEM_ADDR,
        MEM_READ, MEM_WRITE, MEM_WB, BRANCH, HALT
    } state_t;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_GE = 4'h8;
    localparam logic [3:0] CC_LT = 4'h9;
    localparam logic [3:0] CC_GT = 4'hA;
    localparam logic [3:0] CC_LE = 4'hB;
    localparam logic [3:0] CC_AL = 4'hE;

    localparam logic [1:0] TY_DP  = 2'b00;
    localparam logic [1:0] TY_MEM = 2'b01;
    localparam logic [1:0] TY_BR  = 2'b10;
    localparam logic [1:0] TY_ILL = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;

    localparam logic [1:0] M2R_MEM = 2'b00;
    localparam logic [1:0] M2R_PC  = 2'b01;
    localparam logic [1:0] M2R_ALU = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_OFF = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_ONE = 2'b11;

endpackage

// File: rtl/mc_control_unit_if.sv
// Memory strobe / ready handshake between control unit and memory.
// master = control unit, slave = memory.
interface mc_control_unit_if;
    logic MemRead;
    logic MemWrite;
    logic MemReady;

    modport master (output MemRead, output MemWrite, input MemReady);
    modport slave  (input MemRead, input MemWrite, output MemReady);
endinterface

// File: rtl/mc_cond_check.sv
// Condition-code evaluator against registered Z/N/V/C flags.
// Codes C, D and F never pass.
module mc_cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic       i_z,
    input  logic       i_n,
    input  logic       i_v,
    input  logic       i_c,
    output logic       o_pass
);

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            CC_EQ:   o_pass = i_z;
            CC_NE:   o_pass = !i_z;
            CC_CS:   o_pass = i_c;
            CC_CC:   o_pass = !i_c;
            CC_MI:   o_pass = i_n;
            CC_PL:   o_pass = !i_n;
            CC_VS:   o_pass = i_v;
            CC_VC:   o_pass = !i_v;
            CC_GE:   o_pass = (i_n == i_v);
            CC_LT:   o_pass = (i_n != i_v);
            CC_GT:   o_pass = !i_z && (i_n == i_v);
            CC_LE:   o_pass = i_z || (i_n != i_v);
            CC_AL:   o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: fetch/decode/execute sequencing with
// conditional execution, memory handshake timeout and sticky halt.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0
)
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic [11:0]         CInstruction,
    input  logic                Z,
    input  logic                N,
    input  logic                V,
    input  logic                C,
    mc_control_unit_if.master   mem,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                IorD,
    output logic                RegSel,
    output logic                RegDst,
    output logic                PCSrc,
    output logic                ALUSrcA,
    output logic                ZWrite,
    output logic                NWrite,
    output logic                VWrite,
    output logic                CWrite,
    output logic [1:0]          MemToReg,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ALUOperation,
    output logic                Halted
);

    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_wait_cnt, w_wait_nxt;
    logic            w_pass, w_waiting, w_timeout;
    logic            w_mem_rd, w_mem_wr;

    wire [1:0] w_type = CInstruction[7:6];
    wire       w_imm  = CInstruction[5];
    wire       w_bit4 = CInstruction[4];
    wire [2:0] w_op   = CInstruction[3:1];
    wire       w_bit0 = CInstruction[0];

    mc_cond_check u_cond (
        .i_cond (CInstruction[11:8]),
        .i_z    (Z),
        .i_n    (N),
        .i_v    (V),
        .i_c    (C),
        .o_pass (w_pass)
    );

    assign w_waiting = (r_state inside {FETCH, MEM_READ, MEM_WRITE}) && !mem.MemReady;
    assign w_timeout = (MEM_WAIT_MAX > 0) && w_waiting
                       && (r_wait_cnt == CW'(MEM_WAIT_MAX));
    // Counter only survives a cycle that stays in the same waiting state.
    assign w_wait_nxt = (w_state_nxt != r_state || !w_waiting) ? '0
                        : r_wait_cnt + CW'(1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= INIT;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            INIT:      w_state_nxt = FETCH;
            FETCH:
                if (mem.MemReady)   w_state_nxt = DECODE;
                else if (w_timeout) w_state_nxt = HALT;
            DECODE:
                if (!w_pass) w_state_nxt = FETCH;
                else begin
                    unique case (w_type)
                        TY_DP:   w_state_nxt = DP_EXEC;
                        TY_MEM:  w_state_nxt = MEM_ADDR;
                        TY_BR:   w_state_nxt = BRANCH;
                        TY_ILL:  w_state_nxt = HALT;
                        default: w_state_nxt = HALT;
                    endcase
                end
            DP_EXEC:   w_state_nxt = w_bit4 ? FETCH : DP_WB;
            DP_WB:     w_state_nxt = FETCH;
            MEM_ADDR:  w_state_nxt = w_bit0 ? MEM_READ : MEM_WRITE;
            MEM_READ:
                if (mem.MemReady)   w_state_nxt = MEM_WB;
                else if (w_timeout) w_state_nxt = HALT;
            MEM_WRITE:
                if (mem.MemReady)   w_state_nxt = FETCH;
                else if (w_timeout) w_state_nxt = HALT;
            MEM_WB:    w_state_nxt = FETCH;
            BRANCH:    w_state_nxt = FETCH;
            HALT:      w_state_nxt = HALT;
            default:   w_state_nxt = INIT;
        endcase
    end

    always_comb begin
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        IorD         = 1'b0;
        RegSel       = 1'b0;
        RegDst       = 1'b0;
        PCSrc        = 1'b0;
        ALUSrcA      = 1'b0;
        ZWrite       = 1'b0;
        NWrite       = 1'b0;
        VWrite       = 1'b0;
        CWrite       = 1'b0;
        MemToReg     = M2R_MEM;
        ALUSrcB      = SRCB_B;
        ALUOperation = ALU_ADD;
        Halted       = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        unique case (r_state)
            FETCH: begin
                w_mem_rd = 1'b1;
                ALUSrcB  = SRCB_ONE;
                IRWrite  = mem.MemReady;
                PCWrite  = mem.MemReady;
            end
            DECODE: ALUSrcB = SRCB_OFF;
            DP_EXEC, DP_WB: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = w_imm ? SRCB_IMM : SRCB_B;
                ALUOperation = w_op;
                if (r_state == DP_EXEC) begin
                    {ZWrite, NWrite, VWrite, CWrite} = {4{w_bit0}};
                end else begin
                    RegWrite = 1'b1;
                    MemToReg = M2R_ALU;
                end
            end
            MEM_ADDR, MEM_READ, MEM_WRITE: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                IorD     = (r_state != MEM_ADDR);
                w_mem_rd = (r_state == MEM_READ);
                w_mem_wr = (r_state == MEM_WRITE);
                RegSel   = (r_state == MEM_WRITE);
            end
            MEM_WB: RegWrite = 1'b1;
            BRANCH: begin
                PCWrite  = 1'b1;
                PCSrc    = 1'b1;
                RegWrite = w_bit4;
                RegDst   = w_bit4;
                MemToReg = w_bit4 ? M2R_PC : M2R_MEM;
            end
            HALT:    Halted = 1'b1;
            default: ;
        endcase
    end

    assign mem.MemRead  = w_mem_rd;
    assign mem.MemWrite = w_mem_wr;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit and mc_cond_check.
// Two instances: timeout disabled and MEM_WAIT_MAX=4.
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic       pcw, irw, rw, iord, rsel, rdst, pcsrc, asa;
        logic [3:0] fl;
        logic [1:0] m2r, asb;
        logic [2:0] aop;
        logic       mr, mw, h;
    } ov_t;

    localparam ov_t E_ZERO  = '0;
    localparam ov_t E_FRDY  = '{pcw:1'b1, irw:1'b1, asb:2'b11, mr:1'b1, default:'0};
    localparam ov_t E_FWAIT = '{asb:2'b11, mr:1'b1, default:'0};
    localparam ov_t E_DEC   = '{asb:2'b01, default:'0};
    localparam ov_t E_X010  = '{asa:1'b1, aop:3'b010, default:'0};
    localparam ov_t E_X010S = '{asa:1'b1, fl:4'hF, aop:3'b010, default:'0};
    localparam ov_t E_W010  = '{asa:1'b1, rw:1'b1, m2r:2'b10, aop:3'b010, default:'0};
    localparam ov_t E_X100  = '{asa:1'b1, aop:3'b100, default:'0};
    localparam ov_t E_MADDR = '{asa:1'b1, asb:2'b10, default:'0};
    localparam ov_t E_MRD   = '{iord:1'b1, asa:1'b1, asb:2'b10, mr:1'b1, default:'0};
    localparam ov_t E_MWR   = '{iord:1'b1, rsel:1'b1, asa:1'b1, asb:2'b10, mw:1'b1, default:'0};
    localparam ov_t E_MWB   = '{rw:1'b1, m2r:2'b00, default:'0};
    localparam ov_t E_BRL   = '{pcw:1'b1, rw:1'b1, rdst:1'b1, pcsrc:1'b1, m2r:2'b01, default:'0};
    localparam ov_t E_BR    = '{pcw:1'b1, pcsrc:1'b1, default:'0};
    localparam ov_t E_HALT  = '{h:1'b1, default:'0};

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [11:0] CInstr = '0;
    logic        Z = 1'b0, N = 1'b0, V = 1'b0, C = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 Clk = ~Clk;

    mc_control_unit_if mem0 ();
    mc_control_unit_if mem1 ();

    logic pcw0, irw0, rw0, iord0, rsel0, rdst0, pcsrc0, asa0;
    logic zw0, nw0, vw0, cw0, h0;
    logic [1:0] m2r0, asb0;
    logic [2:0] aop0;
    logic pcw1, irw1, rw1, iord1, rsel1, rdst1, pcsrc1, asa1;
    logic zw1, nw1, vw1, cw1, h1;
    logic [1:0] m2r1, asb1;
    logic [2:0] aop1;

    mc_control_unit #(.MEM_WAIT_MAX(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .CInstruction(CInstr),
        .Z(Z), .N(N), .V(V), .C(C), .mem(mem0),
        .PCWrite(pcw0), .IRWrite(irw0), .RegWrite(rw0),
        .IorD(iord0), .RegSel(rsel0), .RegDst(rdst0),
        .PCSrc(pcsrc0), .ALUSrcA(asa0),
        .ZWrite(zw0), .NWrite(nw0), .VWrite(vw0), .CWrite(cw0),
        .MemToReg(m2r0), .ALUSrcB(asb0), .ALUOperation(aop0),
        .Halted(h0)
    );

    mc_control_unit #(.MEM_WAIT_MAX(4)) dut1 (
        .Clk(Clk), .Rst(Rst), .CInstruction(CInstr),
        .Z(Z), .N(N), .V(V), .C(C), .mem(mem1),
        .PCWrite(pcw1), .IRWrite(irw1), .RegWrite(rw1),
        .IorD(iord1), .RegSel(rsel1), .RegDst(rdst1),
        .PCSrc(pcsrc1), .ALUSrcA(asa1),
        .ZWrite(zw1), .NWrite(nw1), .VWrite(vw1), .CWrite(cw1),
        .MemToReg(m2r1), .ALUSrcB(asb1), .ALUOperation(aop1),
        .Halted(h1)
    );

    ov_t o0, o1;
    assign o0 = {pcw0, irw0, rw0, iord0, rsel0, rdst0, pcsrc0, asa0,
                 zw0, nw0, vw0, cw0, m2r0, asb0, aop0,
                 mem0.MemRead, mem0.MemWrite, h0};
    assign o1 = {pcw1, irw1, rw1, iord1, rsel1, rdst1, pcsrc1, asa1,
                 zw1, nw1, vw1, cw1, m2r1, asb1, aop1,
                 mem1.MemRead, mem1.MemWrite, h1};

    logic [3:0] cc_cond;
    logic       cc_z, cc_n, cc_v, cc_c, cc_pass;

    mc_cond_check u_cc (
        .i_cond(cc_cond), .i_z(cc_z), .i_n(cc_n),
        .i_v(cc_v), .i_c(cc_c), .o_pass(cc_pass)
    );

    // {cond, z n v c, expected pass}
    logic [8:0] cc_vec [20] = '{
        {4'h0, 4'b1000, 1'b1}, {4'h0, 4'b0000, 1'b0},
        {4'h1, 4'b0000, 1'b1}, {4'h2, 4'b0001, 1'b1},
        {4'h3, 4'b0001, 1'b0}, {4'h4, 4'b0100, 1'b1},
        {4'h5, 4'b0100, 1'b0}, {4'h6, 4'b0010, 1'b1},
        {4'h7, 4'b0000, 1'b1}, {4'h8, 4'b0110, 1'b1},
        {4'h9, 4'b0100, 1'b1}, {4'h8, 4'b0100, 1'b0},
        {4'hA, 4'b0000, 1'b1}, {4'hA, 4'b1000, 1'b0},
        {4'hB, 4'b0010, 1'b1}, {4'hB, 4'b0110, 1'b0},
        {4'hE, 4'b0000, 1'b1}, {4'hC, 4'b1111, 1'b0},
        {4'hD, 4'b0000, 1'b0}, {4'hF, 4'b1111, 1'b0}
    };

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic st0(input string tag, input state_t s, input ov_t e);
        chk({tag, ".state"}, 32'(dut0.r_state), 32'(s));
        chk({tag, ".outs"}, 32'(o0), 32'(e));
    endtask

    task automatic st1(input string tag, input state_t s, input ov_t e);
        chk({tag, ".state"}, 32'(dut1.r_state), 32'(s));
        chk({tag, ".outs"}, 32'(o1), 32'(e));
    endtask

    task automatic at(input logic rdy, input logic [11:0] ins);
        @(posedge Clk);
        #2;
        mem0.MemReady = rdy;
        CInstr = ins;
        #1;
    endtask

    initial begin
        mem0.MemReady = 1'b1;
        mem1.MemReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            {cc_cond, cc_z, cc_n, cc_v, cc_c} = cc_vec[i][8:1];
            #1;
            chk($sformatf("cc%0d", i), 32'(cc_pass), 32'(cc_vec[i][0]));
        end
        st0("rst", INIT, E_ZERO);
        @(posedge Clk);
        #2;
        st0("rst_hold", INIT, E_ZERO);
        Rst = 1'b1;

        at(1'b1, 12'hE04); st0("t1_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hE04); st0("t1_dec", DECODE, E_DEC);
        at(1'b1, 12'hE04); st0("t1_exec", DP_EXEC, E_X010);
        at(1'b1, 12'hE04); st0("t1_wb", DP_WB, E_W010);

        at(1'b1, 12'h004); st0("t2_fetch", FETCH, E_FRDY);
        at(1'b1, 12'h004); st0("t2_dec", DECODE, E_DEC);
        at(1'b1, 12'h004); st0("t2_skip", FETCH, E_FRDY);
        Z = 1'b1;
        at(1'b1, 12'h004); st0("t2_dec_z", DECODE, E_DEC);
        at(1'b1, 12'h004); st0("t2_exec", DP_EXEC, E_X010);
        at(1'b1, 12'h004); st0("t2_wb", DP_WB, E_W010);
        Z = 1'b0;

        at(1'b1, 12'hE41); st0("t3_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hE41); st0("t3_dec", DECODE, E_DEC);
        at(1'b1, 12'hE41); st0("t3_addr", MEM_ADDR, E_MADDR);
        at(1'b0, 12'hE41); st0("t3_rd0", MEM_READ, E_MRD);
        at(1'b0, 12'hE41); st0("t3_rd1", MEM_READ, E_MRD);
        at(1'b0, 12'hE41); st0("t3_rd2", MEM_READ, E_MRD);
        at(1'b1, 12'hE41); st0("t3_rd3", MEM_READ, E_MRD);
        at(1'b1, 12'hE41); st0("t3_wb", MEM_WB, E_MWB);
        at(1'b1, 12'hE40); st0("t3s_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hE40); st0("t3s_dec", DECODE, E_DEC);
        at(1'b1, 12'hE40); st0("t3s_addr", MEM_ADDR, E_MADDR);
        at(1'b1, 12'hE40); st0("t3s_wr", MEM_WRITE, E_MWR);

        at(1'b1, 12'hE90); st0("t4_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hE90); st0("t4_dec", DECODE, E_DEC);
        at(1'b1, 12'hE90); st0("t4_brl", BRANCH, E_BRL);
        at(1'b1, 12'hE80); st0("t4n_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hE80); st0("t4n_dec", DECODE, E_DEC);
        at(1'b1, 12'hE80); st0("t4n_br", BRANCH, E_BR);

        at(1'b1, 12'hE05); st0("t5_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hE05); st0("t5_dec", DECODE, E_DEC);
        at(1'b1, 12'hE05); st0("t5_exec", DP_EXEC, E_X010S);
        at(1'b1, 12'hE05); st0("t5_wb", DP_WB, E_W010);
        at(1'b1, 12'hE18); st0("t5t_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hE18); st0("t5t_dec", DECODE, E_DEC);
        at(1'b1, 12'hE18); st0("t5t_exec", DP_EXEC, E_X100);

        at(1'b1, 12'hEC0); st0("t6_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hEC0); st0("t6_dec", DECODE, E_DEC);
        for (int i = 0; i < 100; i++) begin
            at(i[0], 12'hEC0);
            st0($sformatf("t6_halt%0d", i), HALT, E_HALT);
        end
        Rst = 1'b0;
        #1;
        st0("t6_rst_halt", INIT, E_ZERO);
        #1;
        Rst = 1'b1;

        at(1'b1, 12'hE41); st0("t6r_fetch", FETCH, E_FRDY);
        at(1'b1, 12'hE41); st0("t6r_dec", DECODE, E_DEC);
        at(1'b1, 12'hE41); st0("t6r_addr", MEM_ADDR, E_MADDR);
        at(1'b0, 12'hE41); st0("t6r_rd", MEM_READ, E_MRD);
        #2;
        Rst = 1'b0;
        #1;
        st0("t6r_rst", INIT, E_ZERO);
        mem1.MemReady = 1'b0;
        #1;
        Rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            at(1'b0, 12'hE04);
            st1($sformatf("to_fetch%0d", i), FETCH, E_FWAIT);
        end
        at(1'b0, 12'hE04); st1("to_halt", HALT, E_HALT);
        st0("to_nolimit", FETCH, E_FWAIT);
        at(1'b0, 12'hE04); st1("to_halt_hold", HALT, E_HALT);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
